fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the RISCV-Lite pipeline. It owns the program counter and issues in-order requests to instruction memory. Returned words are buffered together with their PC in a small FIFO, and the unit presents one instruction per cycle to the decode stage, where the control decoder consumes `if_instr`. It accepts a redirect from the branch/jump resolution logic and a stall from the hazard logic.

## Interface
- `RESET_PC`, 32'h0040_0000, first fetch address after reset
- `DEPTH`, 2, instruction buffer entries; also the maximum number of outstanding requests (power of 2, ≥2)
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: reset, synchronous and active-high
- `imem_req` out 1: fetch request valid
- `imem_addr` out 32: word-aligned fetch address
- `imem_gnt` in 1: memory accepts request this cycle
- `imem_rvalid` in 1: read data valid; responses return in request order, latency ≥1 cycle
- `imem_rdata` in 32: instruction word
- `redirect_valid` in 1: taken branch/jump, single-cycle pulse
- `redirect_pc` in 32: new fetch target
- `stall` in 1: decode cannot accept; hold outputs
- `if_valid` out 1: `if_instr`/`if_pc` valid
- `if_instr` out 32: instruction to decode; `NOP_INSTR` when `if_valid`=0
- `if_pc` out 32: address of `if_instr`

## Operation
- Registers: `fetch_pc`, `resp_pc`, `outstanding` (0..DEPTH), `drop_cnt` (0..DEPTH), FIFO of {pc, instr}.
- Issue: `imem_req` = !rst_cycle && !redirect_valid && (count+outstanding < DEPTH || pop). `imem_addr` = `fetch_pc`. Handshake is `imem_req && imem_gnt`, which does `fetch_pc += 4` and `outstanding++`. `imem_req` may drop without `gnt`; the address is not required to be held.
- Response: on `imem_rvalid`, `outstanding--`. If `drop_cnt`>0, discard the word and `drop_cnt--`. Otherwise push {`resp_pc`, `imem_rdata`} and `resp_pc += 4`.
- Pop: pop = `if_valid && !stall`. Push and pop in the same cycle are legal; occupancy is unchanged.
- Output: FIFO head; `if_valid` = count≠0.
- Redirect (highest priority): FIFO flushed. `fetch_pc` = `resp_pc` = {`redirect_pc`[31:2], 2'b00}. `drop_cnt` = outstanding after this cycle's issue/response accounting. No issue in the redirect cycle. `stall` is ignored for the flush.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- The flow-control rule means the FIFO can never overflow. A push while full is an assertion failure.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=`NOP_INSTR`, `if_pc`=`RESET_PC`. `outstanding`=`drop_cnt`=count=0.
- `rst` asserted mid-operation: all state returns to the reset values on the next edge. In-flight responses arriving after reset are not dropped; the memory is reset from the same `rst`.
- The first cycle after `rst` deasserts issues `RESET_PC`.
- Latency: a response in cycle N appears on `if_*` in cycle N+1. There is no bypass.
- With `gnt`=1, 1-cycle memory latency and no stall, throughput is 1 instr/cycle once filled.
- Redirect in cycle R: `if_valid`=0 in R+1, the `redirect_pc` request issues in R+1, and its instruction is valid in R+3 with 1-cycle memory.
- `stall` holds `if_*` stable. Issue continues until the occupancy+outstanding credit is exhausted.

## Structure
- `my_pkg` gains `NOP_INSTR` = 32'h0000_0013 (addi x0,x0,0) and a `fetch_entry` struct {pc, instr}.
- The sub-module `instr_fifo` is a synchronous FIFO: parameter DEPTH, push/pop/flush, count output, `fetch_entry` payload.

## Test plan
- Reset release, `gnt`=1, 1-cycle memory: addresses 0x400000, 0x400004, 0x400008 on consecutive cycles; `if_pc` follows 2 cycles later with `if_valid` held high.
- `stall` held 3 cycles with the FIFO holding 0x400004: `if_*` stays constant, at most DEPTH words are buffered, and there is no lost or duplicated PC after release.
- Redirect to 0x400103 with 2 requests outstanding: both stale responses are dropped, `imem_addr`=0x400100 in the next cycle, and the next valid `if_pc`=0x400100.
- `gnt` toggling 1-0-1 with 3-cycle memory latency: the in-order sequence is preserved and `outstanding` never exceeds DEPTH.
- `redirect_pc`=0xFFFFFFFC: fetches 0xFFFFFFFC then 0x00000000.
- `rst` pulse while the FIFO is full and stalled: the next cycle shows the reset values, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/my_pkg.sv
// RISCV-Lite shared pipeline types.
// Fetch-stage constants and the fetch buffer entry.
package my_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs.
// Flush clears all entries and wins over push/pop.
module instr_fifo
    import my_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry    wdata_i,
    output fetch_entry    rdata_o,
    output logic [CW-1:0] count_o
);

    localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

    fetch_entry    mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (cnt_q != '0) && !flush_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign count_o = cnt_q;

    // Upstream credit accounting must make this unreachable.
    assert property (@(posedge clk) disable iff (rst)
        !(do_push && !do_pop && cnt_q == FULL));

endmodule

// File: rtl/fetch_unit.sv
// RISCV-Lite instruction fetch: PC, in-order imem requests,
// response buffering and redirect handling.
module fetch_unit
    import my_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [CW:0] LIMIT = DEPTH[CW:0];

    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   resp_pc_q;
    logic [31:0]   resp_pc_d;
    logic [CW-1:0] out_q;
    logic [CW-1:0] out_d;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] drop_d;
    logic [CW-1:0] count;
    logic [CW:0]   credit;
    logic [31:0]   target;
    logic          pop;
    logic          push;
    logic          drop;
    logic          handshake;
    fetch_entry    head;
    fetch_entry    wentry;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign target         = {redirect_pc[31:2], 2'b00};

    // Buffered plus in-flight words may never exceed the buffer size.
    assign credit    = {1'b0, count} + {1'b0, out_q};
    assign if_valid  = count != '0;
    assign pop       = if_valid && !stall;
    assign imem_req  = !rst && !redirect_valid
                     && ((credit < LIMIT) || pop);
    assign imem_addr = fetch_pc_q;
    assign handshake = imem_req && imem_gnt;
    assign drop      = imem_rvalid && (drop_q != '0);
    assign push      = imem_rvalid && !drop && !redirect_valid;

    assign wentry.pc    = resp_pc_q;
    assign wentry.instr = imem_rdata;

    assign if_instr = if_valid ? head.instr : NOP_INSTR;
    assign if_pc    = if_valid ? head.pc : resp_pc_q;

    always_comb begin
        out_d      = out_q + CW'(handshake) - CW'(imem_rvalid);
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            drop_d     = out_d;
        end else begin
            if (handshake) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)      resp_pc_d  = resp_pc_q + 32'd4;
            if (drop)      drop_d     = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .wdata_i (wentry),
        .rdata_o (head),
        .count_o (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order
// variable-latency instruction memory model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b1;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        hold = 1'b0;
    int          lat = 1;
    int          cyc = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    logic [31:0] pend[$];
    int          due[$];
    logic        rst_s;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    // Memory: accepts on req&&gnt, answers in order after lat cycles.
    always @(posedge clk) begin
        rst_s = rst;
        if (rst_s) begin
            pend.delete();
            due.delete();
            out_cnt = 0;
        end else begin
            if (imem_req && imem_gnt) begin
                pend.push_back(imem_addr);
                due.push_back(cyc + lat);
                out_cnt++;
            end
            if (imem_rvalid) out_cnt--;
            if (out_cnt > max_out) max_out = out_cnt;
        end
        cyc++;
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!rst_s && pend.size() > 0 && due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend.pop_front());
            void'(due.pop_front());
        end
    end

    // Decode only accepts what the scoreboard expects.
    always @(posedge clk) begin
        #1;
        stall = hold || (exp_q.size() == 0);
    end

    always @(negedge clk) begin
        if (!rst && if_valid && !stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got pc %h, none expected", if_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (if_pc !== e || if_instr !== mem_word(e)) begin
                    errors++;
                    $display("FAIL sb_pop: got %h/%h expected %h/%h",
                             if_pc, if_instr, e, mem_word(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic drain(input string name, input int lim);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic reset_hold();
        rst = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        reset_hold();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, NOP);
        chk("rst_pc", if_pc, RST_PC);

        // Streaming with 1-cycle memory
        push_seq(RST_PC, 6);
        rst = 1'b0;
        #1;
        chk("t1_req0", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0040_0000);
        tick();
        chk("t1_addr1", imem_addr, 32'h0040_0004);
        tick();
        chk("t1_addr2", imem_addr, 32'h0040_0008);
        chk("t1_req2", 32'(imem_req), 32'd1);
        chk("t1_pc0", if_pc, 32'h0040_0000);
        tick();
        chk("t1_valid1", 32'(if_valid), 32'd1);
        chk("t1_pc1", if_pc, 32'h0040_0004);
        tick();
        chk("t1_valid2", 32'(if_valid), 32'd1);
        chk("t1_pc2", if_pc, 32'h0040_0008);
        drain("t1_drain", 50);

        // Stall held 3 cycles on 0x400004
        reset_hold();
        push_seq(RST_PC, 8);
        rst = 1'b0;
        tick();
        tick();
        chk("t2_pc0", if_pc, 32'h0040_0000);
        hold = 1'b1;
        tick();
        chk("t2_pc_s0", if_pc, 32'h0040_0004);
        chk("t2_ins_s0", if_instr, mem_word(32'h0040_0004));
        tick();
        chk("t2_pc_s1", if_pc, 32'h0040_0004);
        chk("t2_req_s1", 32'(imem_req), 32'd0);
        tick();
        chk("t2_pc_s2", if_pc, 32'h0040_0004);
        chk("t2_ins_s2", if_instr, mem_word(32'h0040_0004));
        chk("t2_req_s2", 32'(imem_req), 32'd0);
        hold = 1'b0;
        drain("t2_drain", 50);

        // Redirect with two requests in flight, 3-cycle memory
        lat = 3;
        reset_hold();
        rst = 1'b0;
        tick();
        tick();
        chk("t3_req_full", 32'(imem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0103;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t3_addr", imem_addr, 32'h0040_0100);
        chk("t3_valid", 32'(if_valid), 32'd0);
        push_seq(32'h0040_0100, 4);
        drain("t3_drain", 60);

        // Grant toggling with 3-cycle memory
        reset_hold();
        max_out = 0;
        push_seq(RST_PC, 8);
        rst = 1'b0;
        for (int k = 0; k < 150 && exp_q.size() != 0; k++) begin
            imem_gnt = (k % 2 == 0);
            tick();
        end
        imem_gnt = 1'b1;
        drain("t4_drain", 10);
        chk("t4_max_out", 32'(max_out), 32'd2);

        // Wrap-around redirect
        lat = 1;
        repeat (10) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("t5_req0", 32'(imem_req), 32'd1);
        chk("t5_valid0", 32'(if_valid), 32'd0);
        push_seq(32'hFFFF_FFFC, 4);
        tick();
        chk("t5_addr1", imem_addr, 32'h0000_0000);
        tick();
        chk("t5_valid2", 32'(if_valid), 32'd1);
        chk("t5_pc2", if_pc, 32'hFFFF_FFFC);
        drain("t5_drain", 50);

        // Reset pulse while full and stalled
        repeat (5) tick();
        chk("t6_full", 32'(if_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_req_rst", 32'(imem_req), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(if_valid), 32'd0);
        chk("t6_instr", if_instr, NOP);
        chk("t6_pc", if_pc, RST_PC);
        chk("t6_addr", imem_addr, RST_PC);
        chk("t6_req", 32'(imem_req), 32'd1);
        push_seq(RST_PC, 3);
        drain("t6_drain", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
